// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg
//   Shared constants for the instruction-fetch prefetcher: reboot address,
//   default queue depth / outstanding limit and chip enable levels.
//   No ports; imported by ifu_fifo and ifu_prefetch.
package ifu_prefetch_pkg;

    localparam int          IFU_XLEN       = 32;
    localparam logic [31:0] REBOOT_ADDRESS = 32'h0000_0000;
    localparam int          IFU_QDEPTH     = 4;
    localparam int          IFU_MAX_OUTST  = 2;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo
//   Synchronous show-ahead FIFO with synchronous clear.
//   Ports:
//     clk_i, rst_i   clock, asynchronous active-high reset
//     clear_i        drop all entries (wins over push/pop)
//     push_i/wdata_i write an entry (accepted when not full, or full with pop)
//     pop_i          remove head (ignored when empty)
//     rdata_o        head entry (valid while !empty_o)
//     count_o        entries held
//     empty_o        no entries
module ifu_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_push, do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full | do_pop);
    assign rdata_o = mem[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: contents are only observed behind count_q.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch
//   Fetch stage: generates fetch PCs, keeps up to MAX_OUTST requests in flight
//   on a req/gnt/rvalid instruction memory, and queues returned instructions
//   (with their PC and branch-prediction info) for decode. Flush/redirect
//   retargets the PC and discards responses of requests issued before it.
//   Ports:
//     clk_i, rst_i                       clock, async active-high reset
//     flush_i/flush_pc_i                 trap flush + target (highest priority)
//     redirect_i/redirect_pc_i           mispredict redirect + target
//     bp_taken_i/bp_next_pc_i            prediction for the PC on imem_addr_o
//     imem_req_o/imem_addr_o/imem_gnt_i  request channel
//     imem_rvalid_i/imem_rdata_i         response channel (in grant order)
//     inst_valid_o/inst_ready_i          decode handshake
//     inst_o/pc_o/pred_taken_o/pred_pc_o head entry
//     slot_end_o                         head is first instruction after redirect
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int              XLEN      = IFU_XLEN,
    parameter int              DEPTH     = IFU_QDEPTH,
    parameter int              MAX_OUTST = IFU_MAX_OUTST,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(REBOOT_ADDRESS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            bp_taken_i,
    input  logic [XLEN-1:0] bp_next_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_pc_o,
    output logic            slot_end_o
);
    localparam int MW  = 2 * XLEN + 1;      // {pc, taken, pred_pc}
    localparam int QW  = XLEN + MW + 1;     // {inst, meta, slot_end}
    localparam int QCW = $clog2(DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTST + 1);

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [OCW-1:0]  discard_q, discard_d;
    logic            slot_pend_q, slot_pend_d;

    logic            retarget, grant, keep;
    logic [XLEN-1:0] target, pred_pc;
    logic [OCW-1:0]  o_count;
    logic [QCW-1:0]  q_count;
    logic            o_pop, o_empty, q_pop, q_empty;
    logic [MW-1:0]   o_rdata;
    logic [QW-1:0]   q_wdata, q_rdata;
    logic [XLEN-1:0] h_inst, h_pc, h_np;
    logic            h_tk, h_se;

    assign retarget = flush_i | redirect_i;
    assign target   = flush_i ? flush_pc_i : redirect_pc_i;

    // Outstanding requests count against queue space so every response
    // already has a slot reserved when it returns.
    assign imem_req_o  = ~rst_i & ~retarget
                       & ((int'(q_count) + int'(o_count)) < DEPTH)
                       & (int'(o_count) < MAX_OUTST);
    assign imem_addr_o = fetch_pc_q;
    assign grant       = imem_req_o & imem_gnt_i;
    assign pred_pc     = bp_taken_i ? align(bp_next_pc_i) : fetch_pc_q + XLEN'(4);

    // Responses returning in the retarget cycle belong to the old stream.
    assign o_pop   = imem_rvalid_i & ~o_empty;
    assign keep    = o_pop & (discard_q == '0) & ~retarget;
    assign q_wdata = {imem_rdata_i, o_rdata, slot_pend_q};
    assign q_pop   = inst_valid_o & inst_ready_i;

    ifu_fifo #(.WIDTH(MW), .DEPTH(MAX_OUTST)) u_outst (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (1'b0),
        .push_i  (grant),
        .wdata_i ({fetch_pc_q, bp_taken_i, pred_pc}),
        .pop_i   (o_pop),
        .rdata_o (o_rdata),
        .count_o (o_count),
        .empty_o (o_empty)
    );

    ifu_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_iq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (retarget),
        .push_i  (keep),
        .wdata_i (q_wdata),
        .pop_i   (q_pop),
        .rdata_o (q_rdata),
        .count_o (q_count),
        .empty_o (q_empty)
    );

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        discard_d   = discard_q;
        slot_pend_d = slot_pend_q;
        if (grant) fetch_pc_d = pred_pc;
        if (o_pop && discard_q != '0) discard_d = discard_q - OCW'(1);
        if (keep) slot_pend_d = 1'b0;
        if (retarget) begin
            fetch_pc_d  = align(target);
            // Everything still in flight after this edge is stale.
            discard_d   = o_count + OCW'(grant) - OCW'(o_pop);
            slot_pend_d = redirect_i & ~flush_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q  <= RESET_PC;
            discard_q   <= '0;
            slot_pend_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            discard_q   <= discard_d;
            slot_pend_q <= slot_pend_d;
        end
    end

    assign inst_valid_o = ~q_empty;
    assign {h_inst, h_pc, h_tk, h_np, h_se} = q_rdata;
    assign inst_o       = inst_valid_o ? h_inst : '0;
    assign pc_o         = inst_valid_o ? h_pc   : '0;
    assign pred_taken_o = inst_valid_o & h_tk;
    assign pred_pc_o    = inst_valid_o ? h_np   : '0;
    assign slot_end_o   = inst_valid_o & h_se;

    // A response with nothing outstanding (e.g. one that straddled a reset)
    // breaks the protocol.
    always @(posedge clk_i) begin
        if (!rst_i && imem_rvalid_i) assert (!o_empty);
    end

endmodule
